// File: rtl/act_arb_pkg.sv
// Shared types and width helpers for the activation-unit arbiter.
package act_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_CHANNELS   = 16;
  localparam int DEF_REQUESTERS = 4;
  localparam int DEF_CW         = idx_w(DEF_CHANNELS);
  localparam int DEF_RW         = idx_w(DEF_REQUESTERS);

  // Requester tag travelling alongside a beat through the activation unit.
  typedef struct packed {
    logic              valid;
    logic [DEF_RW-1:0] id;
  } tag_t;

endpackage

// File: rtl/act_tag_pipe.sv
// DEPTH-stage shift register of requester tags; bit W-1 of each tag is its valid.
module act_tag_pipe #(
  parameter int DEPTH = 2,
  parameter int W     = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] tag_in,
  output logic [W-1:0] tag_out,
  output logic         any_valid
);

  logic [W-1:0] stage [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign tag_out = stage[DEPTH-1];

  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) any_valid = any_valid | stage[i][W-1];
  end

endmodule

// File: rtl/act_arbiter.sv
// Round-robin, burst-locked arbiter in front of a shared ReLU unit, with tag-based result routing.
// Optional ACT_ARB_CHECK_EN: sticky err on tag/act_valid_in mismatch and rsp gated by both.
//
//   state | meaning
//   IDLE  | no grant; pick next requester at/after rr_ptr
//   BURST | grant_id owns the unit until last beat or CHANNELS beats
module act_arbiter
  import act_arb_pkg::*;
#(
  parameter int N           = 16,
  parameter int CHANNELS    = 16,
  parameter int REQUESTERS  = 4,
  parameter int ACT_LATENCY = 2,
  localparam int CW = idx_w(CHANNELS),
  localparam int RW = idx_w(REQUESTERS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [REQUESTERS-1:0]      req_valid,
  input  logic [REQUESTERS*N-1:0]    req_data,
  input  logic [REQUESTERS*CW-1:0]   req_channel,
  input  logic [REQUESTERS-1:0]      req_last,
  output logic [REQUESTERS-1:0]      req_ready,
  output logic [N-1:0]               act_data_out,
  output logic [CW-1:0]              act_channel_out,
  output logic                       act_valid_out,
  input  logic [N-1:0]               act_data_in,
  input  logic [CW-1:0]              act_channel_in,
  input  logic                       act_valid_in,
  output logic [REQUESTERS-1:0]      rsp_valid,
  output logic [N-1:0]               rsp_data,
  output logic [CW-1:0]              rsp_channel,
  output logic [RW-1:0]              grant_id,
  output logic                       busy,
  output logic                       err
);

  state_t                state, state_nx;
  logic [RW-1:0]         rr_ptr, pick, cand, act_id_q;
  logic [CW-1:0]         beat_cnt;
  logic                  found, accept, last_beat;
  tag_t                  tag_in, tag_out;
  logic                  tag_any, rsp_fire;
  logic [REQUESTERS-1:0] rsp_onehot;

  always_comb begin
    found = 1'b0;
    pick  = rr_ptr;
    cand  = '0;
    for (int i = 0; i < REQUESTERS; i++) begin
      cand = RW'((int'(rr_ptr) + i) % REQUESTERS);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == BURST) req_ready[grant_id] = 1'b1;
  end

  assign accept    = (state == BURST) && req_valid[grant_id];
  assign last_beat = accept && (req_last[grant_id] || (beat_cnt == CW'(CHANNELS - 1)));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (found) state_nx = BURST;
      BURST:   if (last_beat) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      grant_id        <= '0;
      rr_ptr          <= '0;
      beat_cnt        <= '0;
      act_valid_out   <= 1'b0;
      act_data_out    <= '0;
      act_channel_out <= '0;
      act_id_q        <= '0;
    end else begin
      state         <= state_nx;
      act_valid_out <= accept;
      if (state == IDLE && found) begin
        grant_id <= pick;
        beat_cnt <= '0;
      end
      if (accept) begin
        act_data_out    <= req_data[int'(grant_id)*N +: N];
        act_channel_out <= req_channel[int'(grant_id)*CW +: CW];
        act_id_q        <= grant_id;
        beat_cnt        <= beat_cnt + 1'b1;
      end
      if (last_beat)
        rr_ptr <= (int'(grant_id) == REQUESTERS - 1) ? '0 : grant_id + 1'b1;
    end
  end

  // The tag enters alongside act_valid_out so its pipe output lines up with act_valid_in.
  always_comb begin
    tag_in.valid = act_valid_out;
    tag_in.id    = act_id_q;
  end

  act_tag_pipe #(
    .DEPTH (ACT_LATENCY),
    .W     ($bits(tag_t))
  ) u_tag_pipe (
    .clk       (clk),
    .rst       (rst),
    .tag_in    (tag_in),
    .tag_out   (tag_out),
    .any_valid (tag_any)
  );

  assign busy = (state == BURST) || act_valid_out || tag_any;

  always_comb begin
    rsp_onehot = '0;
    rsp_onehot[tag_out.id] = 1'b1;
  end

`ifdef ACT_ARB_CHECK_EN
  assign rsp_fire = tag_out.valid && act_valid_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err <= 1'b0;
    else     err <= err | (act_valid_in != tag_out.valid);
  end
`else
  logic unused_valid_in;
  assign unused_valid_in = act_valid_in;
  assign rsp_fire        = tag_out.valid;
  assign err             = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid   <= '0;
      rsp_data    <= '0;
      rsp_channel <= '0;
    end else begin
      rsp_valid <= rsp_fire ? rsp_onehot : '0;
      if (rsp_fire) begin
        rsp_data    <= act_data_in;
        rsp_channel <= act_channel_in;
      end
    end
  end

endmodule

// File: tb/tb_act_arbiter.sv
// Bench for act_arbiter: per-requester beat queues, a ReLU unit model, and a transaction-level timeline model.
module tb_act_arbiter;

  localparam int N = 16, CH = 16, R = 4, LAT = 2, CW = 4, RW = 2, MAXC = 512;

  typedef struct packed {
    logic [N-1:0]  d;
    logic [CW-1:0] ch;
    logic          last;
  } beat_t;

  logic clk = 1'b0, rst = 1'b1, inject = 1'b0;
  logic [R-1:0]    req_valid = '0, req_last = '0, req_ready, rsp_valid;
  logic [R*N-1:0]  req_data = '0;
  logic [R*CW-1:0] req_channel = '0;
  logic [N-1:0]    act_data_out, act_data_in, rsp_data;
  logic [CW-1:0]   act_channel_out, act_channel_in, rsp_channel;
  logic            act_valid_out, act_valid_in, busy, err;
  logic [RW-1:0]   grant_id;

  int total = 0, bad = 0;

  beat_t q[R][$];
  beat_t mq[R][$];
  int sent[R], hold[R];
  logic [R-1:0] acc;
  int stall_r, stall_beat, stall_k;

  logic [R-1:0]  exp_ready[MAXC], exp_rv[MAXC];
  logic          exp_busy[MAXC], exp_av[MAXC], exp_gv[MAXC];
  logic [N-1:0]  exp_ad[MAXC], exp_rd[MAXC];
  logic [CW-1:0] exp_ac[MAXC], exp_rc[MAXC];
  logic [RW-1:0] exp_g[MAXC];

  act_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_channel(req_channel),
    .req_last(req_last), .req_ready(req_ready),
    .act_data_out(act_data_out), .act_channel_out(act_channel_out), .act_valid_out(act_valid_out),
    .act_data_in(act_data_in), .act_channel_in(act_channel_in), .act_valid_in(act_valid_in),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_channel(rsp_channel),
    .grant_id(grant_id), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] relu(input logic [N-1:0] x);
    return x[N-1] ? '0 : x;
  endfunction

  // Two-stage activation unit model.
  logic          s1_v, s2_v;
  logic [N-1:0]  s1_d, s2_d;
  logic [CW-1:0] s1_c, s2_c;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v <= 1'b0; s2_v <= 1'b0; s1_d <= '0; s2_d <= '0; s1_c <= '0; s2_c <= '0;
    end else begin
      s1_v <= act_valid_out; s1_d <= relu(act_data_out); s1_c <= act_channel_out;
      s2_v <= s1_v;          s2_d <= s1_d;               s2_c <= s1_c;
    end
  end
  assign act_valid_in   = s2_v | inject;
  assign act_data_in    = s2_d;
  assign act_channel_in = s2_c;

  task automatic clear_all();
    for (int r = 0; r < R; r++) begin
      q[r].delete();
      sent[r] = 0;
      hold[r] = 0;
    end
    acc = '0; stall_r = -1; stall_beat = 0; stall_k = 0;
    req_valid = '0; req_last = '0; req_data = '0; req_channel = '0; inject = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_all();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Expected timeline from the arbitration rules: arbitrate in one cycle, beats
  // from the next, one bubble between bursts; results LAT+2 cycles after accept.
  task automatic model_build(output int fin);
    int cyc, ptr, r, n, idx, remaining;
    int ms[R];
    bit done;
    beat_t b;
    for (int c = 0; c < MAXC; c++) begin
      exp_ready[c] = '0; exp_rv[c] = '0; exp_busy[c] = 0; exp_av[c] = 0; exp_gv[c] = 0;
      exp_ad[c] = '0; exp_rd[c] = '0; exp_ac[c] = '0; exp_rc[c] = '0; exp_g[c] = '0;
    end
    for (int i = 0; i < R; i++) begin
      mq[i] = q[i];
      ms[i] = 0;
    end
    cyc = 0; ptr = 0; fin = -1;
    forever begin
      remaining = 0;
      for (int i = 0; i < R; i++) remaining += mq[i].size();
      if (remaining == 0) break;
      r = -1;
      for (int i = 0; i < R; i++) begin
        idx = (ptr + i) % R;
        if (r < 0 && mq[idx].size() > 0) r = idx;
      end
      cyc++;
      n = 0; done = 0;
      while (!done) begin
        if (mq[r].size() == 0 || cyc + LAT + 3 + stall_k >= MAXC) return;
        b = mq[r].pop_front();
        exp_ready[cyc][r] = 1'b1;
        exp_busy[cyc]     = 1'b1;
        exp_gv[cyc]       = 1'b1;
        exp_g[cyc]        = RW'(r);
        exp_av[cyc+1]     = 1'b1;
        exp_ad[cyc+1]     = b.d;
        exp_ac[cyc+1]     = b.ch;
        for (int k = 1; k <= LAT + 1; k++) exp_busy[cyc+k] = 1'b1;
        exp_rv[cyc+LAT+2] = R'(1) << r;
        exp_rd[cyc+LAT+2] = relu(b.d);
        exp_rc[cyc+LAT+2] = b.ch;
        n++; ms[r]++;
        done = b.last || (n == CH);
        if (!done && r == stall_r && ms[r] - 1 == stall_beat) begin
          for (int k = 0; k < stall_k; k++) begin
            cyc++;
            exp_ready[cyc][r] = 1'b1;
            exp_busy[cyc]     = 1'b1;
          end
        end
        cyc++;
      end
      ptr = (r + 1) % R;
    end
    fin = cyc + LAT + 3;
  endtask

  task automatic drive();
    for (int r = 0; r < R; r++) begin
      if (acc[r]) begin
        q[r].delete(0);
        sent[r]++;
        if (r == stall_r && sent[r] - 1 == stall_beat && stall_k > 0) hold[r] = stall_k;
      end
      if (hold[r] > 0) begin
        req_valid[r] = 1'b0;
        hold[r]--;
      end else begin
        req_valid[r] = (q[r].size() > 0);
      end
      if (q[r].size() > 0) begin
        req_data[r*N +: N]     = q[r][0].d;
        req_channel[r*CW +: CW] = q[r][0].ch;
        req_last[r]            = q[r][0].last;
      end
    end
  endtask

  task automatic run_scen(input string name, input int len_ovr);
    int fin, len, left;
    model_build(fin);
    total++;
    if (fin < 0) begin
      bad++;
      $display("FAIL %s model_overflow got=%0d need>=0", name, fin);
      return;
    end
    len = (len_ovr > 0) ? len_ovr : fin;
    for (int c = 0; c < len; c++) begin
      drive();
      @(negedge clk);
      total++;
      if (req_ready !== exp_ready[c]) begin
        bad++; $display("FAIL %s req_ready c=%0d got=%b exp=%b", name, c, req_ready, exp_ready[c]);
      end
      total++;
      if (busy !== exp_busy[c]) begin
        bad++; $display("FAIL %s busy c=%0d got=%b exp=%b", name, c, busy, exp_busy[c]);
      end
      total++;
      if (act_valid_out !== exp_av[c]) begin
        bad++; $display("FAIL %s act_valid_out c=%0d got=%b exp=%b", name, c, act_valid_out, exp_av[c]);
      end
      if (exp_av[c]) begin
        total++;
        if (act_data_out !== exp_ad[c] || act_channel_out !== exp_ac[c]) begin
          bad++; $display("FAIL %s act_out c=%0d got=%h/%0d exp=%h/%0d", name, c,
                          act_data_out, act_channel_out, exp_ad[c], exp_ac[c]);
        end
      end
      if (exp_gv[c]) begin
        total++;
        if (grant_id !== exp_g[c]) begin
          bad++; $display("FAIL %s grant_id c=%0d got=%0d exp=%0d", name, c, grant_id, exp_g[c]);
        end
      end
      total++;
      if (rsp_valid !== exp_rv[c]) begin
        bad++; $display("FAIL %s rsp_valid c=%0d got=%b exp=%b", name, c, rsp_valid, exp_rv[c]);
      end
      if (exp_rv[c] != '0) begin
        total++;
        if (rsp_data !== exp_rd[c] || rsp_channel !== exp_rc[c]) begin
          bad++; $display("FAIL %s rsp_payload c=%0d got=%h/%0d exp=%h/%0d", name, c,
                          rsp_data, rsp_channel, exp_rd[c], exp_rc[c]);
        end
      end
      total++;
      if (err !== 1'b0) begin
        bad++; $display("FAIL %s err c=%0d got=%b exp=0", name, c, err);
      end
      acc = req_valid & req_ready;
      @(posedge clk); #1;
    end
    if (len_ovr == 0) begin
      left = 0;
      for (int r = 0; r < R; r++) left += q[r].size();
      total++;
      if (left != 0) begin
        bad++; $display("FAIL %s drain got=%0d beats_left exp=0", name, left);
      end
    end
  endtask

  task automatic check_all_zero(input string name);
    total++;
    if (req_ready !== '0 || act_valid_out !== 1'b0 || act_data_out !== '0 || act_channel_out !== '0 ||
        rsp_valid !== '0 || rsp_data !== '0 || rsp_channel !== '0 || grant_id !== '0 ||
        busy !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL %s outputs got rdy=%b av=%b ad=%h ac=%h rv=%b rd=%h rc=%h g=%0d busy=%b err=%b exp=all_zero",
               name, req_ready, act_valid_out, act_data_out, act_channel_out, rsp_valid, rsp_data,
               rsp_channel, grant_id, busy, err);
    end
  endtask

  task automatic push_burst(input int r, input int len, input bit nolast, input bit rnd, input logic [N-1:0] base);
    beat_t b;
    for (int j = 0; j < len; j++) begin
      b.d    = rnd ? N'($urandom) : base + N'(j);
      b.ch   = CW'(j);
      b.last = !nolast && (j == len - 1);
      q[r].push_back(b);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_all();
    @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("post_reset_idle");
  endtask

  task automatic test_single();
    do_reset();
    push_burst(2, 16, 1'b0, 1'b0, 16'hFF00);
    run_scen("single", 0);
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int r = 0; r < R; r++) push_burst(r, 3, 1'b0, 1'b1, '0);
    push_burst(0, 3, 1'b0, 1'b1, '0);
    run_scen("round_robin", 0);
  endtask

  task automatic test_no_last();
    do_reset();
    push_burst(1, 16, 1'b1, 1'b1, '0);
    push_burst(1, 4, 1'b0, 1'b1, '0);
    push_burst(2, 2, 1'b0, 1'b1, '0);
    run_scen("no_last", 0);
  endtask

  task automatic test_stall();
    do_reset();
    push_burst(1, 8, 1'b0, 1'b1, '0);
    push_burst(3, 4, 1'b0, 1'b1, '0);
    stall_r = 1; stall_beat = 3; stall_k = 3;
    run_scen("stall", 0);
  endtask

  task automatic test_random();
    int nb, len;
    bit nl;
    for (int it = 0; it < 5; it++) begin
      do_reset();
      for (int r = 0; r < R; r++) begin
        nb = $urandom_range(0, 2);
        for (int b = 0; b < nb; b++) begin
          len = $urandom_range(1, 16);
          nl  = (len == 16) && ($urandom_range(0, 1) == 1);
          push_burst(r, len, nl, 1'b1, '0);
        end
      end
      run_scen("random", 0);
    end
  endtask

  task automatic test_reset_in_flight();
    do_reset();
    push_burst(0, 3, 1'b0, 1'b0, 16'h0100);
    run_scen("flight", 4);
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL flight busy_before_rst got=%b exp=1", busy);
    end
    rst = 1'b1;
    clear_all();
    #1;
    check_all_zero("flight_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      total++;
      if (rsp_valid !== '0 || busy !== 1'b0) begin
        bad++; $display("FAIL flight_after c=%0d got rv=%b busy=%b exp rv=0 busy=0", c, rsp_valid, busy);
      end
      @(posedge clk); #1;
    end
  endtask

`ifdef ACT_ARB_CHECK_EN
  task automatic test_check_err();
    do_reset();
    @(negedge clk);
    total++;
    if (err !== 1'b0) begin
      bad++; $display("FAIL check_err before got=%b exp=0", err);
    end
    @(posedge clk); #1;
    inject = 1'b1;
    @(posedge clk); #1;
    inject = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++;
      if (err !== 1'b1 || rsp_valid !== '0) begin
        bad++; $display("FAIL check_err c=%0d got err=%b rv=%b exp err=1 rv=0", c, err, rsp_valid);
      end
      @(posedge clk); #1;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_no_last();
    test_stall();
    test_random();
    test_reset_in_flight();
`ifdef ACT_ARB_CHECK_EN
    test_check_err();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
